led_string_rx: RTL and testbench

Single-wire LED serial receiver: samples a WS2812-style pulse-width-coded `sdi` line, such as the output of `string_driver`, and recovers `DATA_WIDTH`-bit pixel words plus frame boundaries. It mirrors the transmit path in the LED output chain and serves two roles:

- loopback checking of the string outputs on hardware;
- capturing an upstream LED data stream so it can be written back into the pixel FIFO.

---
 rtl/led_string_rx.sv | 222 ++++++++++++++++++++++
 tb/tb_led_string_rx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_string_rx.sv
// Single-wire WS2812-style receiver: decodes pulse-width-coded sdi into pixel words and frame ends.
// Optional LED_RX_PASSTHRU_EN regenerates the chained stream on sdo; otherwise sdo is tied low.
module led_string_rx #(
    parameter int unsigned CLK_PERIOD_NS    = 50,
    parameter int unsigned DATA_WIDTH       = 24,
    parameter int unsigned BIT_THRESHOLD_NS = 600,
    parameter int unsigned MIN_HIGH_NS      = 150,
    parameter int unsigned MAX_HIGH_NS      = 1100,
    parameter int unsigned LATCH_NS         = 50000,
    parameter int unsigned MAX_PIXELS       = 150
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            sdi,
    output logic [DATA_WIDTH-1:0]           pixel_data,
    output logic                            pixel_data_valid,
    output logic [$clog2(MAX_PIXELS+1)-1:0] pixel_index,
    output logic                            frame_done,
    output logic [$clog2(MAX_PIXELS+1)-1:0] frame_pixels,
    output logic                            rx_error,
    output logic                            rx_active,
    output logic                            sdo
);

    localparam int unsigned THRESH_CYC = BIT_THRESHOLD_NS / CLK_PERIOD_NS;
    localparam int unsigned MIN_CYC    = MIN_HIGH_NS / CLK_PERIOD_NS;
    localparam int unsigned MAX_CYC    = MAX_HIGH_NS / CLK_PERIOD_NS;
    localparam int unsigned LATCH_CYC  = LATCH_NS / CLK_PERIOD_NS;
    localparam int unsigned CW         = $clog2(MAX_PIXELS + 1);
    localparam int unsigned HW         = $clog2(MAX_CYC + 2);
    localparam int unsigned LW         = $clog2(LATCH_CYC + 1);
    localparam int unsigned BW         = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] SYNC = 2'd0;
    localparam logic [1:0] IDLE = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] LOW  = 2'd3;

    logic                  sdi_meta_q, sdi_meta_d, sdi_s_q, sdi_s_d, sdi_prev_q, sdi_prev_d;
    logic [1:0]            state_q, state_d;
    logic                  from_low_q, from_low_d;
    logic [HW-1:0]         hi_cnt_q, hi_cnt_d;
    logic [LW-1:0]         lo_cnt_q, lo_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-2:0] shreg_q, shreg_d;
    logic [CW-1:0]         pix_cnt_q, pix_cnt_d;
    logic [DATA_WIDTH-1:0] pixel_data_q, pixel_data_d, shifted;
    logic                  pixel_valid_q, pixel_valid_d;
    logic [CW-1:0]         pixel_index_q, pixel_index_d;
    logic                  frame_done_q, frame_done_d;
    logic [CW-1:0]         frame_pixels_q, frame_pixels_d;
    logic                  rx_error_q, rx_error_d;
    logic                  rx_active_q, rx_active_d;
    logic                  rise, fall, lo_reached;

    assign rise = sdi_s_q & ~sdi_prev_q;
    assign fall = ~sdi_s_q & sdi_prev_q;

    always_comb begin
        sdi_meta_d = sdi;
        sdi_s_d    = sdi_meta_q;
        sdi_prev_d = sdi_s_q;

        hi_cnt_d = '0;
        if (sdi_s_q) begin
            hi_cnt_d = (hi_cnt_q == HW'(MAX_CYC + 1)) ? hi_cnt_q : hi_cnt_q + 1'b1;
        end
        // lo_cnt holds across high levels so a glitch does not restart the latch timer
        lo_cnt_d = lo_cnt_q;
        if (!sdi_s_q && lo_cnt_q != LW'(LATCH_CYC)) begin
            lo_cnt_d = lo_cnt_q + 1'b1;
        end
        lo_reached = (lo_cnt_d == LW'(LATCH_CYC));
        shifted    = {shreg_q, (hi_cnt_q >= HW'(THRESH_CYC))};

        state_d        = state_q;
        from_low_d     = from_low_q;
        bit_cnt_d      = bit_cnt_q;
        shreg_d        = shreg_q;
        pix_cnt_d      = pix_cnt_q;
        pixel_data_d   = pixel_data_q;
        pixel_valid_d  = 1'b0;
        pixel_index_d  = pixel_index_q;
        frame_done_d   = 1'b0;
        frame_pixels_d = frame_pixels_q;
        rx_error_d     = 1'b0;
        rx_active_d    = rx_active_q;

        case (state_q)
            SYNC: begin
                if (sdi_s_q) begin
                    lo_cnt_d = '0;
                end else if (lo_reached) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d    = HIGH;
                    from_low_d = 1'b0;
                end
            end
            HIGH: begin
                if (sdi_s_q && hi_cnt_d == HW'(MAX_CYC + 1)) begin
                    rx_error_d  = 1'b1;
                    state_d     = SYNC;
                    bit_cnt_d   = '0;
                    shreg_d     = '0;
                    pix_cnt_d   = '0;
                    rx_active_d = 1'b0;
                    lo_cnt_d    = '0;
                end else if (fall) begin
                    if (hi_cnt_q < HW'(MIN_CYC)) begin
                        state_d = from_low_q ? LOW : IDLE;
                    end else begin
                        shreg_d     = shifted[DATA_WIDTH-2:0];
                        rx_active_d = 1'b1;
                        lo_cnt_d    = '0;
                        state_d     = LOW;
                        if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                            bit_cnt_d     = '0;
                            pixel_data_d  = shifted;
                            pixel_valid_d = 1'b1;
                            pixel_index_d = pix_cnt_q;
                            if (pix_cnt_q != CW'(MAX_PIXELS)) begin
                                pix_cnt_d = pix_cnt_q + 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (rise) begin
                    state_d    = HIGH;
                    from_low_d = 1'b1;
                end else if (lo_reached) begin
                    frame_done_d   = 1'b1;
                    frame_pixels_d = pix_cnt_q;
                    pix_cnt_d      = '0;
                    rx_active_d    = 1'b0;
                    state_d        = IDLE;
                    // a partial pixel at latch time is dropped and flagged
                    if (bit_cnt_q != '0) begin
                        rx_error_d = 1'b1;
                        bit_cnt_d  = '0;
                        shreg_d    = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sdi_meta_q     <= 1'b0;
            sdi_s_q        <= 1'b0;
            sdi_prev_q     <= 1'b0;
            state_q        <= SYNC;
            from_low_q     <= 1'b0;
            hi_cnt_q       <= '0;
            lo_cnt_q       <= '0;
            bit_cnt_q      <= '0;
            shreg_q        <= '0;
            pix_cnt_q      <= '0;
            pixel_data_q   <= '0;
            pixel_valid_q  <= 1'b0;
            pixel_index_q  <= '0;
            frame_done_q   <= 1'b0;
            frame_pixels_q <= '0;
            rx_error_q     <= 1'b0;
            rx_active_q    <= 1'b0;
        end else begin
            sdi_meta_q     <= sdi_meta_d;
            sdi_s_q        <= sdi_s_d;
            sdi_prev_q     <= sdi_prev_d;
            state_q        <= state_d;
            from_low_q     <= from_low_d;
            hi_cnt_q       <= hi_cnt_d;
            lo_cnt_q       <= lo_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shreg_q        <= shreg_d;
            pix_cnt_q      <= pix_cnt_d;
            pixel_data_q   <= pixel_data_d;
            pixel_valid_q  <= pixel_valid_d;
            pixel_index_q  <= pixel_index_d;
            frame_done_q   <= frame_done_d;
            frame_pixels_q <= frame_pixels_d;
            rx_error_q     <= rx_error_d;
            rx_active_q    <= rx_active_d;
        end
    end

    assign pixel_data       = pixel_data_q;
    assign pixel_data_valid = pixel_valid_q;
    assign pixel_index      = pixel_index_q;
    assign frame_done       = frame_done_q;
    assign frame_pixels     = frame_pixels_q;
    assign rx_error         = rx_error_q;
    assign rx_active        = rx_active_q;

`ifdef LED_RX_PASSTHRU_EN
    logic sdo_q, sdo_d;

    // pixel 0 is consumed here; later pixels are forwarded to the next device
    assign sdo_d = sdi_s_q && (state_q != SYNC) && (pix_cnt_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            sdo_q <= 1'b0;
        end else begin
            sdo_q <= sdo_d;
        end
    end

    assign sdo = sdo_q;
`else
    assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_led_string_rx.sv
// Randomised self-checking bench for led_string_rx with a pulse-level reference decoder.
module tb_led_string_rx;

    localparam int DW      = 24;
    localparam int MIN_CYC = 3;
    localparam int THRESH  = 12;
    localparam int MAX_CYC = 22;
    localparam int LATCH   = 1000;
    localparam int MAXPIX  = 150;

    logic        clk = 1'b0;
    logic        reset;
    logic        sdi;
    logic [23:0] pixel_data;
    logic        pixel_data_valid;
    logic [7:0]  pixel_index;
    logic        frame_done;
    logic [7:0]  frame_pixels;
    logic        rx_error;
    logic        rx_active;
    logic        sdo;

    led_string_rx dut (
        .clk              (clk),
        .reset            (reset),
        .sdi              (sdi),
        .pixel_data       (pixel_data),
        .pixel_data_valid (pixel_data_valid),
        .pixel_index      (pixel_index),
        .frame_done       (frame_done),
        .frame_pixels     (frame_pixels),
        .rx_error         (rx_error),
        .rx_active        (rx_active),
        .sdo              (sdo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;  // 0 pixel, 1 frame end, 2 overlong-pulse error
        logic [31:0] val;
        int          idx;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t act_q[$];
    int  exp_rd = 0;
    int  act_rd = 0;
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  sdo_bad = 0;
    bit  sdi_hist [0:65535];
    bit  pass_hist [0:65535];
    int  bnd_len [4] = '{3, 11, 12, 22};

    // Reference decoder state
    bit          m_sync;
    int          m_lowrun;
    logic [23:0] m_bits;
    int          m_nbits;
    int          m_pix;
    bit          m_inframe;
    bit          m_pass;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (pixel_data_valid)
                act_q.push_back('{kind: 0, val: 32'(pixel_data), idx: int'(pixel_index), cyc: cyc});
            if (frame_done)
                act_q.push_back('{kind: 1, val: 32'(rx_error), idx: int'(frame_pixels), cyc: cyc});
            else if (rx_error)
                act_q.push_back('{kind: 2, val: 32'(0), idx: 0, cyc: cyc});
`ifdef LED_RX_PASSTHRU_EN
            if (sdo !== ((cyc >= 3) ? (pass_hist[cyc-3] & sdi_hist[cyc-3]) : 1'b0)) sdo_bad++;
`else
            if (sdo !== 1'b0) sdo_bad++;
`endif
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_desync();
        m_sync = 0; m_lowrun = 0; m_bits = '0; m_nbits = 0;
        m_pix = 0; m_inframe = 0; m_pass = 0;
    endtask

    task automatic model_seg(input bit level, input int len, input int c0);
        if (level) begin
            if (!m_sync) begin
                m_lowrun = 0;
                for (int i = 0; i < len; i++) pass_hist[c0+i] = 1'b0;
            end else if (len > MAX_CYC) begin
                exp_q.push_back('{kind: 2, val: 32'(0), idx: 0, cyc: c0 + MAX_CYC + 3});
                for (int i = 0; i < len; i++) pass_hist[c0+i] = (i <= MAX_CYC) ? m_pass : 1'b0;
                model_desync();
            end else begin
                for (int i = 0; i < len; i++) pass_hist[c0+i] = m_pass;
                if (len >= MIN_CYC) begin
                    m_bits    = {m_bits[22:0], (len >= THRESH)};
                    m_nbits++;
                    m_lowrun  = 0;
                    m_inframe = 1;
                    if (m_nbits == DW) begin
                        exp_q.push_back('{kind: 0, val: {8'h0, m_bits}, idx: m_pix,
                                          cyc: c0 + len + 3});
                        if (m_pix < MAXPIX) m_pix++;
                        m_nbits = 0;
                        m_pass  = 1;
                    end
                end
            end
        end else begin
            for (int i = 0; i < len; i++) pass_hist[c0+i] = m_pass;
            if (!m_sync) begin
                m_lowrun += len;
                if (m_lowrun >= LATCH) m_sync = 1;
            end else if (m_inframe) begin
                if (m_lowrun + len >= LATCH) begin
                    exp_q.push_back('{kind: 1, val: 32'(m_nbits != 0), idx: m_pix,
                                      cyc: c0 + (LATCH - m_lowrun) + 3});
                    m_nbits = 0; m_bits = '0; m_pix = 0; m_inframe = 0; m_pass = 0;
                end
                m_lowrun += len;
            end
        end
    endtask

    task automatic send_seg(input bit level, input int len);
        model_seg(level, len, cyc);
        for (int i = 0; i < len; i++) begin
            sdi = level;
            sdi_hist[cyc] = level;
            @(negedge clk);
        end
    endtask

    // Sends the top nbits of val; glitch_at >= 0 splits that bit's low phase with a 2-cycle glitch
    task automatic send_word(input logic [23:0] val, input int nbits, input int t0, input int t1,
                             input int per, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            int h;
            h = val[DW-1-i] ? t1 : t0;
            send_seg(1'b1, h);
            if (i == glitch_at) begin
                send_seg(1'b0, 6);
                send_seg(1'b1, 2);
                send_seg(1'b0, per - h - 8);
            end else begin
                send_seg(1'b0, per - h);
            end
        end
    endtask

    task automatic send_rand_pixel(input logic [23:0] val);
        for (int b = DW - 1; b >= 0; b--) begin
            send_seg(1'b1, val[b] ? int'($urandom_range(22, 12)) : int'($urandom_range(11, 3)));
            if ($urandom_range(7, 0) == 0) begin
                send_seg(1'b0, $urandom_range(4, 2));
                send_seg(1'b1, $urandom_range(2, 1));
                send_seg(1'b0, $urandom_range(4, 2));
            end else begin
                send_seg(1'b0, $urandom_range(12, 4));
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sdi   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst pixel_data", pixel_data, 0);
        check("rst pixel_data_valid", pixel_data_valid, 0);
        check("rst pixel_index", pixel_index, 0);
        check("rst frame_done", frame_done, 0);
        check("rst frame_pixels", frame_pixels, 0);
        check("rst rx_error", rx_error, 0);
        check("rst rx_active", rx_active, 0);
        check("rst sdo", sdo, 0);
        reset = 1'b0;
        model_desync();
    endtask

    task automatic compare_events(input string tag);
        check({tag, " event count"}, act_q.size() - act_rd, exp_q.size() - exp_rd);
        while (exp_rd < exp_q.size() && act_rd < act_q.size()) begin
            check({tag, " kind"}, act_q[act_rd].kind, exp_q[exp_rd].kind);
            check({tag, " value"}, act_q[act_rd].val, exp_q[exp_rd].val);
            check({tag, " index"}, act_q[act_rd].idx, exp_q[exp_rd].idx);
            check({tag, " cycle"}, act_q[act_rd].cyc, exp_q[exp_rd].cyc);
            exp_rd++;
            act_rd++;
        end
        exp_rd = exp_q.size();
        act_rd = act_q.size();
        check({tag, " sdo mismatches"}, sdo_bad, 0);
    endtask

    initial begin
        reset = 1'b1;
        sdi   = 1'b0;
        model_desync();
        @(negedge clk);

        // Basic pixel, single-pixel frame
        do_reset();
        send_seg(1'b0, 1050);
        send_word(24'hA5C3F0, DW, 8, 16, 25, -1);
        check("active mid-frame", rx_active, 1);
        send_seg(1'b0, 1100);
        check("active after latch", rx_active, 0);
        check("pixel_data hold", pixel_data, 24'hA5C3F0);
        compare_events("basic");

        // Activity from reset with too short a gap must not be decoded
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_seg(1'b1, 10);
            send_seg(1'b0, 10);
        end
        send_seg(1'b0, 900);
        send_word(24'h123456, DW, 8, 16, 25, -1);
        send_seg(1'b0, 1100);
        send_word(24'h654321, DW, 8, 16, 25, -1);
        send_seg(1'b0, 1100);
        compare_events("sync");

        // Glitch inside the low phase of a bit
        send_word(24'h00FF00, DW, 8, 16, 25, 5);
        send_seg(1'b0, 1100);
        compare_events("glitch");

        // Overlong pulse mid-pixel, then recovery
        send_word(24'hFFFFFF, 10, 8, 16, 25, -1);
        send_seg(1'b1, 30);
        send_seg(1'b0, 1100);
        send_word(24'h3C5A96, DW, 8, 16, 25, -1);
        send_seg(1'b0, 1100);
        compare_events("overlong");

        // Three pixels plus a partial pixel at latch
        send_word(24'h111111, DW, 8, 16, 25, -1);
        send_word(24'h222222, DW, 8, 16, 25, -1);
        send_word(24'h333333, DW, 8, 16, 25, -1);
        send_word(24'hABCDEF, 12, 8, 16, 25, -1);
        send_seg(1'b0, 1100);
        compare_events("partial");

        // Three-pixel frame for the forwarding path
        send_word(24'hC0FFEE, DW, 8, 16, 25, -1);
        send_word(24'h5A5A5A, DW, 8, 16, 25, -1);
        send_word(24'hF00F0F, DW, 8, 16, 25, -1);
        send_seg(1'b0, 1100);
        compare_events("chain");

        // Pulse widths on each decision boundary, then an overlong pulse of exactly MAX+1
        for (int i = 0; i < DW; i++) begin
            send_seg(1'b1, bnd_len[i % 4]);
            send_seg(1'b0, 6);
        end
        send_seg(1'b0, 1100);
        send_seg(1'b1, MAX_CYC + 1);
        send_seg(1'b0, 1100);
        compare_events("boundary");

        // Randomised frames with occasional glitches
        for (int f = 0; f < 4; f++) begin
            int np;
            np = $urandom_range(3, 1);
            for (int p = 0; p < np; p++) send_rand_pixel(24'($urandom));
            send_seg(1'b0, 1100);
            compare_events("random");
        end

        // Reset in the middle of a pixel
        send_word(24'h0F0F0F, 10, 8, 16, 25, -1);
        do_reset();
        send_seg(1'b0, 1100);
        send_word(24'h7E57ED, DW, 8, 16, 25, -1);
        send_seg(1'b0, 1100);
        compare_events("midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
